// File: rtl/video_scan_doubler_pkg.sv
// video_scan_doubler_pkg: line counter type and lock limits shared by the scan doubler.
package video_scan_doubler_pkg;
  localparam int LINE_CNT_BITS = 11;
  typedef logic [LINE_CNT_BITS-1:0] line_cnt_t;
  localparam int unsigned LOCK_MIN = 256;
  localparam int unsigned LOCK_MAX = 2046;
  function automatic logic lock_ok(input int unsigned cur, input int unsigned prev);
    return cur >= LOCK_MIN && cur <= LOCK_MAX && prev >= LOCK_MIN && prev <= LOCK_MAX &&
      (cur > prev ? cur - prev : prev - cur) <= 1;
  endfunction
endpackage

// File: rtl/video_line_buffer.sv
// video_line_buffer: two-bank 1-bit line memory with one write port and a registered read port.
module video_line_buffer #(
  parameter int LINE_PIXELS = 640
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic                           wr_bank,
  input  logic [$clog2(LINE_PIXELS)-1:0] wr_x,
  input  logic                           wr_data,
  input  logic                           rd_bank,
  input  logic [$clog2(LINE_PIXELS)-1:0] rd_x,
  output logic                           rd_data
);
  localparam int AW = $clog2(2 * LINE_PIXELS);
  logic mem [2 * LINE_PIXELS];
  logic [AW-1:0] wa, ra;
  always_comb begin
    wa = wr_bank ? AW'(LINE_PIXELS) + AW'(wr_x) : AW'(wr_x);
    ra = rd_bank ? AW'(LINE_PIXELS) + AW'(rd_x) : AW'(rd_x);
  end
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wr_data;
    rd_data <= mem[ra];
  end
endmodule

// File: rtl/video_scan_doubler.sv
// video_scan_doubler: line-doubles a 15.6 kHz 1-bit raster into a 31 kHz raster
// through a ping-pong line buffer, regenerating horizontal sync on the output side.
module video_scan_doubler
  import video_scan_doubler_pkg::*;
#(
  parameter int LINE_PIXELS   = 640,
  parameter int CAPTURE_START = 0,
  parameter int OUT_START     = 96,
  parameter int HSYNC_TICKS   = 96,
  parameter int NOMINAL_LINE  = 1024,
  parameter int CNT_WIDTH     = $bits(line_cnt_t)
) (
  input  logic wb_clock_i,
  input  logic reset_i,
  input  logic pixel_clk_en_i,
  input  logic dbl_clk_en_i,
  input  logic h_sync_i,
  input  logic v_sync_i,
  input  logic video_i,
  output logic vga_h_sync_o,
  output logic vga_v_sync_o,
  output logic vga_video_o,
  output logic locked_o
);
  localparam int XW = $clog2(LINE_PIXELS);
  typedef logic [CNT_WIDTH-1:0] cnt_t;
  cnt_t in_cnt, out_cnt, measured, cnt_nxt, out_nxt, wr_off, rd_off, line_len;
  logic hs_q, wr_bank, rd_bank, hs_edge, we, rd_en, rd_data, vs_line, hs_s1, vs_s1, en_s1;
  // The edge tick's own pixel already lands at in_cnt = 1 in the new bank.
  always_comb begin
    hs_edge  = pixel_clk_en_i & h_sync_i & ~hs_q;
    cnt_nxt  = hs_edge ? cnt_t'(1) : &in_cnt ? in_cnt : in_cnt + cnt_t'(1);
    wr_off   = cnt_nxt - cnt_t'(CAPTURE_START);
    we       = pixel_clk_en_i && cnt_nxt >= cnt_t'(CAPTURE_START) && wr_off < cnt_t'(LINE_PIXELS);
    line_len = locked_o ? measured : cnt_t'(NOMINAL_LINE);
    out_nxt  = hs_edge || out_cnt >= line_len - cnt_t'(1) ? '0 : out_cnt + cnt_t'(1);
    rd_off   = out_cnt - cnt_t'(OUT_START);
    rd_en    = locked_o && out_cnt >= cnt_t'(OUT_START) && rd_off < cnt_t'(LINE_PIXELS);
  end
  video_line_buffer #(.LINE_PIXELS(LINE_PIXELS)) u_buf (
    .clk     (wb_clock_i),
    .we      (we),
    .wr_bank (wr_bank ^ hs_edge),
    .wr_x    (wr_off[XW-1:0]),
    .wr_data (video_i),
    .rd_bank (rd_bank),
    .rd_x    (rd_off[XW-1:0]),
    .rd_data (rd_data)
  );
  // Sync and enable take one stage to line up with the synchronous buffer read.
  always_ff @(posedge wb_clock_i or posedge reset_i) begin
    if (reset_i) begin
      hs_q         <= 1'b0;
      in_cnt       <= '0;
      measured     <= '0;
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      locked_o     <= 1'b0;
      out_cnt      <= '0;
      vs_line      <= 1'b0;
      hs_s1        <= 1'b0;
      vs_s1        <= 1'b0;
      en_s1        <= 1'b0;
      vga_h_sync_o <= 1'b0;
      vga_v_sync_o <= 1'b0;
      vga_video_o  <= 1'b0;
    end else begin
      if (pixel_clk_en_i) begin
        hs_q    <= h_sync_i;
        in_cnt  <= cnt_nxt;
        wr_bank <= wr_bank ^ hs_edge;
        if (hs_edge) begin
          measured <= in_cnt;
          rd_bank  <= wr_bank;
          locked_o <= lock_ok(32'(in_cnt), 32'(measured));
        end
      end
      if (dbl_clk_en_i) begin
        out_cnt <= out_nxt;
        if (out_nxt == '0) vs_line <= v_sync_i;
      end
      hs_s1        <= out_cnt < cnt_t'(HSYNC_TICKS);
      vs_s1        <= vs_line;
      en_s1        <= rd_en;
      vga_h_sync_o <= hs_s1;
      vga_v_sync_o <= vs_s1;
      vga_video_o  <= en_s1 & rd_data;
    end
  end
endmodule

// File: tb/tb_video_scan_doubler.sv
// tb_video_scan_doubler: directed line-doubling, lock, sync and reset checks.
module tb_video_scan_doubler;
  logic clk = 1'b0, reset_i, pixel_clk_en_i, dbl_clk_en_i, h_sync_i, v_sync_i, video_i;
  logic vga_h_sync_o, vga_v_sync_o, vga_video_o, locked_o;
  int errors = 0, checks = 0;
  int t, line_len, lit_x;
  int clk_n = 0, last_rise = 0, hs_period = -1, hs_width = -1, v_delta = -1;
  int lit_cnt = 0, lit_pos = -1, lc1 = -1, lp1 = -1, lc2 = -1, lp2 = -1;
  logic h_prev = 1'b0, v_prev = 1'b0;

  video_scan_doubler dut (
    .wb_clock_i     (clk),
    .reset_i        (reset_i),
    .pixel_clk_en_i (pixel_clk_en_i),
    .dbl_clk_en_i   (dbl_clk_en_i),
    .h_sync_i       (h_sync_i),
    .v_sync_i       (v_sync_i),
    .video_i        (video_i),
    .vga_h_sync_o   (vga_h_sync_o),
    .vga_v_sync_o   (vga_v_sync_o),
    .vga_video_o    (vga_video_o),
    .locked_o       (locked_o)
  );

  always #5 clk = ~clk;

  // Output observer: h_sync period/width in clocks, lit pixels per output line.
  always @(posedge clk) begin
    #2;
    clk_n++;
    if (vga_h_sync_o === 1'b1 && !h_prev) begin
      hs_period = clk_n - last_rise;
      last_rise = clk_n;
      lc2 = lc1; lp2 = lp1; lc1 = lit_cnt; lp1 = lit_pos;
      lit_cnt = 0; lit_pos = -1;
    end
    if (vga_h_sync_o === 1'b0 && h_prev) hs_width = clk_n - last_rise;
    if (vga_video_o === 1'b1) begin
      if (lit_cnt == 0) lit_pos = clk_n - last_rise;
      lit_cnt++;
    end
    if (vga_v_sync_o === 1'b1 && !v_prev) v_delta = clk_n - last_rise;
    h_prev = vga_h_sync_o === 1'b1;
    v_prev = vga_v_sync_o === 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pix(input int n);
    repeat (n) begin
      t = (t >= line_len) ? 1 : t + 1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        pixel_clk_en_i = (i == 0);
        dbl_clk_en_i   = (i == 0 || i == 2);
        h_sync_i       = (t <= 8);
        video_i        = (t == lit_x);
      end
    end
  endtask

  task automatic to_end();
    while (t < line_len) pix(1);
  endtask

  initial begin
    reset_i = 1'b1; pixel_clk_en_i = 1'b0; dbl_clk_en_i = 1'b0;
    h_sync_i = 1'b0; v_sync_i = 1'b0; video_i = 1'b0;
    t = 974; line_len = 1024; lit_x = 0;
    repeat (3) @(negedge clk);
    chk("rst_hsync", vga_h_sync_o, 0);
    chk("rst_vsync", vga_v_sync_o, 0);
    chk("rst_video", vga_video_o, 0);
    chk("rst_locked", locked_o, 0);
    reset_i = 1'b0;
    to_end();
    pix(1024);
    chk("lock_after_edge1", locked_o, 0);
    lit_x = 5;
    pix(1024);
    lit_x = 0;
    chk("lock_after_edge2", locked_o, 0);
    pix(2);
    chk("lock_after_edge3", locked_o, 1);
    to_end();
    pix(2);
    chk("line_a_lit_count", lc2, 2);
    chk("line_a_lit_pos", lp2, 202);
    chk("line_b_lit_count", lc1, 2);
    chk("line_b_lit_pos", lp1, 202);
    chk("hsync_period", hs_period, 2048);
    chk("hsync_width", hs_width, 192);
    line_len = 1025;
    to_end();
    line_len = 1024;
    pix(2);
    chk("jitter_1025_locked", locked_o, 1);
    to_end();
    pix(2);
    chk("jitter_1024_locked", locked_o, 1);
    line_len = 1100; lit_x = 5;
    to_end();
    line_len = 1024; lit_x = 0;
    pix(2);
    chk("jitter_1100_unlocked", locked_o, 0);
    to_end();
    pix(2);
    chk("unlocked_line_a_dark", lc2, 0);
    chk("unlocked_line_b_dark", lc1, 0);
    pix(198);
    v_sync_i = 1'b1;
    pix(300);
    chk("vsync_held_midline", vga_v_sync_o, 0);
    pix(20);
    chk("vsync_at_line_start", vga_v_sync_o, 1);
    chk("vsync_aligned_hsync", v_delta, 0);
    v_sync_i = 1'b0;
    to_end();
    pix(2);
    chk("relock_before_hold", locked_o, 1);
    line_len = 3010;
    to_end();
    chk("hold_hsync_period", hs_period, 2048);
    line_len = 1024;
    pix(2);
    chk("saturated_unlocked", locked_o, 0);
    to_end();
    chk("freerun_hsync_period", hs_period, 2048);
    chk("freerun_still_unlocked", locked_o, 0);
    pix(2);
    to_end();
    pix(10);
    chk("relock_before_reset", locked_o, 1);
    chk("hsync_high_before_reset", vga_h_sync_o, 1);
    reset_i = 1'b1;
    #1;
    chk("midreset_hsync", vga_h_sync_o, 0);
    chk("midreset_vsync", vga_v_sync_o, 0);
    chk("midreset_video", vga_video_o, 0);
    chk("midreset_locked", locked_o, 0);
    pix(2);
    reset_i = 1'b0;
    to_end();
    pix(2);
    to_end();
    pix(2);
    chk("recover_edge2_unlocked", locked_o, 0);
    to_end();
    pix(2);
    chk("recover_edge3_locked", locked_o, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
